// File: rtl/uart_boot_pkg.sv
// Shared definitions for the UART boot controller.
// Holds the frame parser state encoding and the protocol byte constants.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StLen,
    StData,
    StCsum,
    StResp,
    StRun
  } state_e;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_GO    = 8'h02;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

endpackage

// File: rtl/uart_boot_ctrl.sv
// UART boot controller: parses framed commands from a UART byte stream, writes
// payload words into instruction memory and releases the CPU from reset.
//
// Frame: 0xA5, cmd, payload, csum (XOR of every byte after sync). Fields are
// little-endian.
//   WRITE (0x01): addr(4) len(2, words) data(len*4) csum
//   GO    (0x02): addr(4) csum
//
// Ports
//   Clk, Rst            clock, asynchronous active-high reset
//   rx_data/rx_valid    received byte and its one-cycle strobe
//   tx_data/tx_valid/tx_ready  response byte handshake (ACK 0x06 / NAK 0x15)
//   mem_addr/mem_wdata/mem_we/mem_ack  word write port, held until acked
//   cpu_rst, boot_addr  CPU reset and reset vector
//   busy, err           frame in progress, sticky error
module uart_boot_ctrl
  import uart_boot_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 50000000,
  parameter logic [31:0] RST_BOOT_ADDR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        cpu_rst,
  output logic [31:0] boot_addr,
  output logic        busy,
  output logic        err
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;          // byte index within the current field
  logic        is_go_q, is_go_d;
  logic        go_ok_q, go_ok_d;      // ACKed GO: leave RESP for RUN
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;          // length shifter, then words remaining
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  resp_q, resp_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [31:0] boot_addr_q, boot_addr_d;
  logic        err_q, err_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  logic        active, timeout, cmd_ok, word_done, overrun, accept;
  logic [31:0] addr_full, word_full;
  logic [15:0] len_full;

  assign active    = state_q inside {StCmd, StAddr, StLen, StData, StCsum};
  assign timeout   = active && !rx_valid && (tmo_cnt_q == 32'(TIMEOUT_CYC - 1));
  assign cmd_ok    = (rx_data == CMD_WRITE) || (rx_data == CMD_GO);
  // Fields arrive LSB first: shift new bytes in from the top.
  assign addr_full = {rx_data, addr_q[31:8]};
  assign len_full  = {rx_data, len_q[15:8]};
  assign word_full = {rx_data, word_q[31:8]};
  assign word_done = (state_q == StData) && rx_valid && (idx_q == 2'd3);
  // A previous word still waiting for its ack cannot be replaced.
  assign overrun   = word_done && mem_we_q;
  assign accept    = tx_valid && tx_ready;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (rx_valid && rx_data == SYNC) state_d = StCmd;
      StCmd: begin
        if (timeout) state_d = StResp;
        else if (rx_valid) state_d = cmd_ok ? StAddr : StResp;
      end
      StAddr: begin
        if (timeout) state_d = StResp;
        else if (rx_valid && idx_q == 2'd3) state_d = is_go_q ? StCsum : StLen;
      end
      StLen: begin
        if (timeout) state_d = StResp;
        else if (rx_valid && idx_q == 2'd1) state_d = (len_full == 16'd0) ? StCsum : StData;
      end
      StData: begin
        if (timeout || overrun) state_d = StResp;
        else if (word_done && len_q == 16'd1) state_d = StCsum;
      end
      StCsum: if (timeout || rx_valid) state_d = StResp;
      StResp: if (accept) state_d = go_ok_q ? StRun : StIdle;
      StRun:  state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; the response is withheld until any pending write retires.
  always_comb begin
    tx_valid = (state_q == StResp) && !mem_we_q;
    busy     = !(state_q inside {StIdle, StRun});
  end

  // Datapath next-state
  always_comb begin
    idx_d       = idx_q;
    is_go_d     = is_go_q;
    go_ok_d     = go_ok_q;
    addr_d      = addr_q;
    len_d       = len_q;
    word_d      = word_q;
    csum_d      = csum_q;
    resp_d      = resp_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    cpu_rst_d   = cpu_rst_q;
    boot_addr_d = boot_addr_q;
    err_d       = err_q;
    tmo_cnt_d   = (active && !rx_valid && !timeout) ? tmo_cnt_q + 32'd1 : 32'd0;

    if (state_d != state_q) begin
      idx_d = 2'd0;
    end else if (rx_valid && (state_q inside {StAddr, StLen, StData})) begin
      idx_d = idx_q + 2'd1;
    end

    if (mem_we_q && mem_ack) begin
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q + 32'd4;
    end

    case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == SYNC) begin
          csum_d  = 8'h00;
          is_go_d = 1'b0;
          go_ok_d = 1'b0;
        end
      end
      StCmd: begin
        if (rx_valid) begin
          csum_d  = csum_q ^ rx_data;
          is_go_d = (rx_data == CMD_GO);
          if (!cmd_ok) resp_d = NAK;
        end
      end
      StAddr: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          addr_d = addr_full;
          if (idx_q == 2'd3 && !is_go_q) mem_addr_d = addr_full;
        end
      end
      StLen: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          len_d  = len_full;
        end
      end
      StData: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          word_d = word_full;
          if (word_done) begin
            if (mem_we_q) begin
              err_d  = 1'b1;
              resp_d = NAK;
            end else begin
              mem_we_d    = 1'b1;
              mem_wdata_d = word_full;
              len_d       = len_q - 16'd1;
            end
          end
        end
      end
      StCsum: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            resp_d = ACK;
            if (is_go_q) begin
              boot_addr_d = addr_q;
              go_ok_d     = 1'b1;
            end
          end else begin
            resp_d = NAK;
            err_d  = 1'b1;
          end
        end
      end
      StResp: if (accept && go_ok_q) cpu_rst_d = 1'b0;
      default: ;
    endcase

    if (timeout) begin
      resp_d = NAK;
      err_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      idx_q       <= 2'd0;
      is_go_q     <= 1'b0;
      go_ok_q     <= 1'b0;
      addr_q      <= 32'd0;
      len_q       <= 16'd0;
      word_q      <= 32'd0;
      csum_q      <= 8'd0;
      resp_q      <= 8'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      boot_addr_q <= RST_BOOT_ADDR;
      err_q       <= 1'b0;
      tmo_cnt_q   <= 32'd0;
    end else begin
      idx_q       <= idx_d;
      is_go_q     <= is_go_d;
      go_ok_q     <= go_ok_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      resp_q      <= resp_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_rst_q   <= cpu_rst_d;
      boot_addr_q <= boot_addr_d;
      err_q       <= err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign tx_data   = resp_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_rst   = cpu_rst_q;
  assign boot_addr = boot_addr_q;
  assign err       = err_q;

endmodule

// File: doc/uart_boot_ctrl.md
UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000000, inter-byte timeout in Clk cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter RST_BOOT_ADDR, default 32'h0000_0000, boot_addr value at reset.
REQ-003 SHALL have ports: Clk in 1, system clock; one clock domain only.
REQ-004 SHALL have ports: Rst in 1, asynchronous, active-high reset.
REQ-005 SHALL have ports: rx_data in 8, received UART byte; rx_valid in 1, one-cycle strobe.
REQ-006 SHALL have ports: tx_data out 8, response byte; tx_valid out 1; tx_ready in 1, byte accepted when tx_valid&tx_ready.
REQ-007 SHALL have ports: mem_addr out 32, mem_wdata out 32, mem_we out 1, mem_ack in 1; word write to instruction memory.
REQ-008 SHALL have ports: cpu_rst out 1, active-high CPU reset; boot_addr out 32, CPU reset vector.
REQ-009 SHALL have ports: busy out 1, frame in progress; err out 1, sticky error flag.

Function
REQ-010 SHALL parse frames: 0xA5 sync, cmd, payload, checksum; multi-byte fields little-endian.
REQ-011 SHALL accept cmd 0x01 WRITE: addr(4), len(2, word count), len*4 data bytes, csum(1).
REQ-012 SHALL accept cmd 0x02 GO: addr(4), csum(1).
REQ-013 SHALL compute checksum as XOR of all bytes after sync, excluding csum; match when equal to received csum.
REQ-014 SHALL implement states IDLE, CMD, ADDR, LEN, DATA, CSUM, RESP, RUN.
REQ-015 IDLE: bytes other than 0xA5 silently dropped; 0xA5 -> CMD.
REQ-016 CMD: 0x01/0x02 -> ADDR; any other value -> RESP with NAK.
REQ-017 ADDR -> LEN (WRITE) or CSUM (GO) after 4th byte; LEN -> DATA, or CSUM if len==0.
REQ-018 DATA: every 4th byte SHALL complete a word, drive mem_addr/mem_wdata and raise mem_we on the next cycle.
REQ-019 mem_we SHALL stay high until the cycle mem_ack is sampled high, then drop; mem_addr then increments by 4, wrapping mod 2^32.
REQ-020 A word completing while mem_we is still high SHALL be an overrun: discard word, set err, enter RESP with NAK after frame aborts.
REQ-021 Writes are not held back for the checksum; a NAKed WRITE leaves memory possibly modified.
REQ-022 CSUM: match -> RESP with ACK 0x06; mismatch -> RESP with NAK 0x15 and err set.
REQ-023 RESP: tx_valid high with tx_data stable until accepted; then IDLE, or RUN after an ACKed GO.
REQ-024 RESP SHALL wait for mem_we low before leaving; rx bytes arriving in RESP or RUN are dropped.
REQ-025 Timeout: in CMD, ADDR, LEN, DATA, CSUM, a counter SHALL count cycles since the last rx_valid; reaching TIMEOUT_CYC -> RESP with NAK, err set.
REQ-026 GO with good checksum SHALL latch boot_addr from the frame's addr field in the CSUM cycle.
REQ-027 cpu_rst SHALL deassert in the cycle after the ACK is accepted; RUN is terminal until Rst.
REQ-028 busy SHALL be high in all states except IDLE and RUN.
REQ-029 err SHALL be sticky until Rst; a subsequent good frame does not clear it.

Reset
REQ-030 Rst SHALL force, asynchronously: state IDLE, cpu_rst 1, boot_addr RST_BOOT_ADDR, mem_we 0, tx_valid 0, tx_data 0, mem_addr 0, mem_wdata 0, busy 0, err 0, timeout counter 0.
REQ-031 Rst mid-frame or mid-write SHALL abandon the operation; no response byte is sent.

Structure
REQ-032 Package uart_boot_pkg SHALL hold the state enum and the constants SYNC 0xA5, CMD_WRITE 0x01, CMD_GO 0x02, ACK 0x06, NAK 0x15.
REQ-033 The block SHALL be a single module with no sub-module; UART PHY and memory are external.

Verification
REQ-034 WRITE addr 0x100, len 2, data 0x11223344, 0xAABBCCDD, good csum -> two writes (0x100, 0x11223344) and (0x104, 0xAABBCCDD), then tx 0x06.
REQ-035 Same frame with csum bit-flipped -> both writes occur, tx 0x15, err=1, cpu_rst stays 1.
REQ-036 GO addr 0x8000_0000, good csum, tx_ready delayed 5 cycles -> tx_data 0x06 held 5 cycles; boot_addr=0x8000_0000; cpu_rst 0 the cycle after acceptance.
REQ-037 Sync then cmd 0x7F -> tx 0x15; then garbage 0x00 0x55 in IDLE -> no response, busy 0.
REQ-038 TIMEOUT_CYC=100, WRITE stalled after 2 addr bytes -> NAK on cycle 100 after the last byte, err=1, back to IDLE.
REQ-039 mem_ack withheld across 2 word completions -> overrun NAK, err=1; Rst asserted in DATA -> all outputs at reset values immediately.
